jtag_axi_lite_regbank: RTL and testbench

AXI4-Lite slave register bank that consumes the 64-bit m_axi4_lite master port of jtag_axi_debugger_ip, which is currently tied off at top level. It gives JTAG-side software a control/status window next to the DDR3 AXI path:
- ID and scratch registers
- LED control
- free-running cycle counter
- DDR calibration status
- write-transaction counter

Single outstanding read and single outstanding write. Fully registered outputs.

---
 rtl/jtag_axi_lite_regbank.sv | 210 +++++++++++++++++++++
 tb/tb_jtag_axi_lite_regbank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_axi_lite_regbank.sv
// AXI4-Lite control/status register bank sitting on the JTAG debugger's m_axi4_lite port.
// Holds ID, scratch, LED, cycle counter, DDR calibration status and a write counter.
module jtag_axi_lite_regbank #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [63:0]           ID_VALUE   = 64'h4A54_4147_4158_0001
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    init_calib_complete,
  output logic [7:0]              led_out
);

  localparam logic [2:0] IDX_ID      = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_LED     = 3'd2;
  localparam logic [2:0] IDX_CYCLE   = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;
  localparam logic [2:0] IDX_WRCOUNT = 3'd5;
  localparam logic [2:0] IDX_CTRL    = 3'd6;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  r_awHeld;
  logic                  r_wHeld;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic [63:0]           r_wData;
  logic [7:0]            r_wStrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [63:0]           r_rdata;
  logic [63:0]           r_scratch;
  logic [7:0]            r_ledCtrl;
  logic [63:0]           r_cycleCount;
  logic [63:0]           r_wrCount;

  logic                  w_awFire;
  logic                  w_wFire;
  logic                  w_awHave;
  logic                  w_wHave;
  logic                  w_doWrite;
  logic                  w_bFire;
  logic                  w_awHeldNext;
  logic                  w_wHeldNext;
  logic                  w_bvalidNext;
  logic [ADDR_WIDTH-1:0] w_wrAddr;
  logic [63:0]           w_wrData;
  logic [7:0]            w_wrStrb;
  logic [ADDR_WIDTH-1:0] w_wrOff;
  logic [2:0]            w_wrIdx;
  logic                  w_wrOk;
  logic                  w_wrOkay;
  logic                  w_clear;
  logic                  w_arFire;
  logic                  w_rvalidNext;
  logic [ADDR_WIDTH-1:0] w_rdOff;
  logic [2:0]            w_rdIdx;
  logic [63:0]           w_rdData;
  logic                  w_rdErr;
  logic                  w_unused;

  // AW and W may arrive in either order; the write commits on the edge where both are present.
  assign w_awFire     = s_axi_awvalid & r_awready;
  assign w_wFire      = s_axi_wvalid & r_wready;
  assign w_awHave     = r_awHeld | w_awFire;
  assign w_wHave      = r_wHeld | w_wFire;
  assign w_doWrite    = w_awHave & w_wHave & ~r_bvalid;
  assign w_bFire      = r_bvalid & s_axi_bready;
  assign w_awHeldNext = w_awHave & ~w_bFire;
  assign w_wHeldNext  = w_wHave & ~w_bFire;
  assign w_bvalidNext = w_doWrite | (r_bvalid & ~s_axi_bready);

  assign w_wrAddr = r_awHeld ? r_awAddr : s_axi_awaddr;
  assign w_wrData = r_wHeld ? r_wData : s_axi_wdata;
  assign w_wrStrb = r_wHeld ? r_wStrb : s_axi_wstrb;
  assign w_wrOff  = w_wrAddr - BASE_ADDR;
  assign w_wrIdx  = w_wrOff[5:3];
  assign w_wrOk   = (w_wrOff[ADDR_WIDTH-1:6] == '0) &&
                    (w_wrIdx == IDX_SCRATCH || w_wrIdx == IDX_LED || w_wrIdx == IDX_CTRL);
  assign w_wrOkay = w_doWrite & w_wrOk;
  assign w_clear  = w_wrOkay & (w_wrIdx == IDX_CTRL) & w_wrData[0] & w_wrStrb[0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_awHeld  <= 1'b0;
      r_wHeld   <= 1'b0;
      r_awAddr  <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_awHeld  <= w_awHeldNext;
      r_wHeld   <= w_wHeldNext;
      if (w_awFire) r_awAddr <= s_axi_awaddr;
      if (w_wFire) begin
        r_wData <= s_axi_wdata;
        r_wStrb <= s_axi_wstrb;
      end
      r_bvalid  <= w_bvalidNext;
      if (w_doWrite) r_bresp <= w_wrOk ? RESP_OKAY : RESP_SLVERR;
      r_awready <= ~w_awHeldNext & ~w_bvalidNext;
      r_wready  <= ~w_wHeldNext & ~w_bvalidNext;
    end
  end

  // A CTRL clear wins over the per-cycle and per-write increments in the same cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_scratch    <= '0;
      r_ledCtrl    <= '0;
      r_cycleCount <= '0;
      r_wrCount    <= '0;
    end else begin
      if (w_wrOkay && w_wrIdx == IDX_SCRATCH) begin
        for (int b = 0; b < 8; b++) begin
          if (w_wrStrb[b]) r_scratch[8*b +: 8] <= w_wrData[8*b +: 8];
        end
      end
      if (w_wrOkay && w_wrIdx == IDX_LED && w_wrStrb[0]) r_ledCtrl <= w_wrData[7:0];
      r_cycleCount <= w_clear ? 64'd0 : r_cycleCount + 64'd1;
      if (w_clear) r_wrCount <= '0;
      else if (w_wrOkay && r_wrCount != '1) r_wrCount <= r_wrCount + 64'd1;
    end
  end

  assign w_arFire     = s_axi_arvalid & r_arready;
  assign w_rvalidNext = w_arFire | (r_rvalid & ~s_axi_rready);
  assign w_rdOff      = s_axi_araddr - BASE_ADDR;
  assign w_rdIdx      = w_rdOff[5:3];

  always_comb begin
    w_rdData = '0;
    w_rdErr  = 1'b0;
    if (w_rdOff[ADDR_WIDTH-1:6] != '0) begin
      w_rdErr = 1'b1;
    end else begin
      case (w_rdIdx)
        IDX_ID:      w_rdData = ID_VALUE;
        IDX_SCRATCH: w_rdData = r_scratch;
        IDX_LED:     w_rdData = {56'd0, r_ledCtrl};
        IDX_CYCLE:   w_rdData = r_cycleCount;
        IDX_STATUS:  w_rdData = {63'd0, init_calib_complete};
        IDX_WRCOUNT: w_rdData = r_wrCount;
        IDX_CTRL:    w_rdData = '0;
        default:     w_rdErr  = 1'b1;
      endcase
    end
  end

  // Read data is captured from pre-edge register values, so a same-cycle write is not visible.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rvalid  <= w_rvalidNext;
      r_arready <= ~w_rvalidNext;
      if (w_arFire) begin
        r_rdata <= w_rdData;
        r_rresp <= w_rdErr ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign w_unused = ^{s_axi_awprot, s_axi_wlast, s_axi_arprot, w_wrOff[2:0], w_rdOff[2:0]};

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign led_out       = r_ledCtrl;

endmodule

// File: tb/tb_jtag_axi_lite_regbank.sv
// Self-checking bench for jtag_axi_lite_regbank: directed scenarios plus randomized
// AXI4-Lite traffic compared against a register-map model kept in the bench.
module tb_jtag_axi_lite_regbank;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        init_calib_complete;
  logic [7:0]  led_out;

  int checkCount = 0;
  int errorCount = 0;
  int tbCycle = 0;

  logic [63:0]     mScratch;
  logic [7:0]      mLed;
  longint unsigned mWrCount;
  int              cycleBase;

  localparam logic [63:0] ID_CONST = 64'h4A54_4147_4158_0001;

  jtag_axi_lite_regbank dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .init_calib_complete(init_calib_complete), .led_out(led_out)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) tbCycle <= tbCycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mScratch = '0;
    mLed     = '0;
    mWrCount = 0;
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int awDly, input int wDly, input int bDly,
                          output logic [1:0] resp, output int wrEdge);
    bit awDone = 0, wDone = 0, leak = 0, awHs, wHs;
    int cyc = 0;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!(awDone && wDone) && cyc < 60) begin
      s_axi_awvalid = !awDone && cyc >= awDly;
      s_axi_wvalid  = !wDone && cyc >= wDly;
      if (awDone && s_axi_awready) leak = 1;
      if (wDone && s_axi_wready) leak = 1;
      awHs = s_axi_awvalid && s_axi_awready;
      wHs  = s_axi_wvalid && s_axi_wready;
      @(posedge sys_clk); #1;
      awDone |= awHs;
      wDone  |= wHs;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    checkOutput("aw_w_done", {awDone, wDone}, 2'b11);
    wrEdge = tbCycle;
    checkOutput("b_latency", s_axi_bvalid, 1'b1);
    for (int i = 0; i < bDly; i++) begin
      if (!s_axi_bvalid || s_axi_awready || s_axi_wready) leak = 1;
      @(posedge sys_clk); #1;
    end
    s_axi_bready = 1'b1;
    resp = s_axi_bresp;
    @(posedge sys_clk); #1;
    s_axi_bready = 1'b0;
    checkOutput("hold_ready", leak, 1'b0);
    checkOutput("ready_back", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
  endtask

  task automatic axiRead(input logic [31:0] addr, input int rDly,
                         output logic [63:0] data, output logic [1:0] resp, output int arEdge);
    int guard = 0;
    bit stable = 1;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && guard < 50) begin
      @(posedge sys_clk); #1;
      guard++;
    end
    @(posedge sys_clk); #1;
    s_axi_arvalid = 1'b0;
    arEdge = tbCycle;
    checkOutput("r_latency", {s_axi_rvalid, s_axi_rlast}, 2'b11);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    for (int i = 0; i < rDly; i++) begin
      @(posedge sys_clk); #1;
      if (!s_axi_rvalid || s_axi_rdata !== data || s_axi_rresp !== resp) stable = 0;
    end
    s_axi_rready = 1'b1;
    @(posedge sys_clk); #1;
    s_axi_rready = 1'b0;
    checkOutput("r_hold", stable, 1'b1);
    checkOutput("ar_back", {s_axi_rvalid, s_axi_arready}, 2'b01);
  endtask

  // Write through the bus and fold the effect into the register-map model.
  task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                               input int awDly, input int wDly, input int bDly);
    logic [1:0] resp;
    int wrEdge;
    bit ok;
    int idx;
    axiWrite(addr, data, strb, awDly, wDly, bDly, resp, wrEdge);
    idx = int'(addr[5:3]);
    ok  = (addr < 32'd64) && (idx == 1 || idx == 2 || idx == 6);
    checkOutput("bresp", resp, ok ? 2'b00 : 2'b10);
    if (ok) begin
      if (idx == 6 && data[0] && strb[0]) begin
        mWrCount  = 0;
        cycleBase = wrEdge;
      end else begin
        if (mWrCount != 64'hFFFF_FFFF_FFFF_FFFF) mWrCount++;
        if (idx == 1) begin
          for (int b = 0; b < 8; b++) if (strb[b]) mScratch[8*b +: 8] = data[8*b +: 8];
        end
        if (idx == 2 && strb[0]) mLed = data[7:0];
      end
    end
  endtask

  task automatic readCheck(input logic [31:0] addr, input int rDly, output logic [63:0] data, output int arEdge);
    logic [1:0]  resp;
    logic [63:0] expData;
    bit err;
    axiRead(addr, rDly, data, resp, arEdge);
    err = 0;
    expData = '0;
    if (addr >= 32'd64) err = 1;
    else case (int'(addr[5:3]))
      0: expData = ID_CONST;
      1: expData = mScratch;
      2: expData = {56'd0, mLed};
      3: expData = 64'(arEdge - cycleBase - 1);
      4: expData = {63'd0, init_calib_complete};
      5: expData = mWrCount;
      6: expData = '0;
      default: err = 1;
    endcase
    checkOutput("rdata", data, expData);
    checkOutput("rresp", resp, err ? 2'b10 : 2'b00);
  endtask

  initial begin
    logic [63:0] d1, d2;
    int e1, e2, gap, sel;
    logic [31:0] addr;

    sys_rst = 1'b1;
    {s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast} = '0;
    {s_axi_wvalid, s_axi_bready, s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready} = '0;
    init_calib_complete = 1'b1;
    modelReset();
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 5'b0);
    checkOutput("reset_data", {s_axi_rdata, s_axi_rresp, s_axi_bresp, led_out}, '0);
    sys_rst = 1'b0;
    cycleBase = tbCycle;
    @(posedge sys_clk); #1;
    checkOutput("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    readCheck(32'h00, 0, d1, e1);
    checkOutput("id_value", d1, 64'h4A54_4147_4158_0001);

    applyStimulus(32'h08, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0);
    applyStimulus(32'h08, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0, 0, 0);
    readCheck(32'h08, 1, d1, e1);
    checkOutput("scratch_merge", d1, 64'h1122_3344_BBBB_BBBB);
    readCheck(32'h28, 0, d1, e1);
    checkOutput("wr_count_two", d1, 64'd2);

    applyStimulus(32'h08, 64'hDEAD_BEEF_0123_4567, 8'hFF, 3, 0, 5);
    readCheck(32'h08, 0, d1, e1);
    readCheck(32'h28, 0, d1, e1);

    applyStimulus(32'h10, 64'hFFFF_FFFF_FFFF_FFA5, 8'hFF, 1, 2, 0);
    @(posedge sys_clk); #1;
    checkOutput("led_out", led_out, 8'hA5);
    readCheck(32'h10, 0, d1, e1);
    checkOutput("led_readback", d1, 64'h0000_0000_0000_00A5);

    applyStimulus(32'h18, 64'h1234, 8'hFF, 0, 0, 0);
    applyStimulus(32'h38, 64'h5678, 8'hFF, 0, 0, 0);
    readCheck(32'h40, 0, d1, e1);
    readCheck(32'h28, 0, d1, e1);

    init_calib_complete = 1'b0;
    readCheck(32'h20, 0, d1, e1);
    init_calib_complete = 1'b1;
    readCheck(32'h20, 0, d1, e1);

    readCheck(32'h18, 0, d1, e1);
    gap = $urandom_range(3, 20);
    repeat (gap) @(posedge sys_clk);
    #1;
    readCheck(32'h18, 2, d2, e2);
    checkOutput("cycle_delta", d2 - d1, 64'(e2 - e1));
    applyStimulus(32'h30, 64'h1, 8'h01, 0, 0, 0);
    readCheck(32'h18, 0, d1, e1);
    checkOutput("cycle_small", d1 < 64'd4, 1'b1);
    readCheck(32'h28, 0, d1, e1);
    checkOutput("wr_count_cleared", d1, 64'd0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) addr = {26'd0, 3'(sel), 3'($urandom)};
      else if (sel == 8) addr = 32'h40 + 32'($urandom_range(0, 63));
      else addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      init_calib_complete = 1'($urandom);
      if ($urandom_range(0, 1) == 1)
        applyStimulus(addr, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
      else
        readCheck(addr, $urandom_range(0, 3), d1, e1);
    end

    s_axi_araddr  = 32'h00;
    s_axi_arvalid = 1'b1;
    @(posedge sys_clk); #1;
    s_axi_arvalid = 1'b0;
    checkOutput("pre_reset_rvalid", s_axi_rvalid, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("async_reset", {s_axi_rvalid, s_axi_arready, s_axi_awready, s_axi_bvalid}, 4'b0);
    checkOutput("async_reset_led", led_out, 8'h00);
    modelReset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    cycleBase = tbCycle;
    @(posedge sys_clk); #1;
    checkOutput("ready_after_rerst", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_rvalid}, 4'b1110);
    readCheck(32'h08, 0, d1, e1);
    readCheck(32'h18, 0, d1, e1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
